// File: rtl/osd_spi_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : osd_spi_writer                                                   |
// | Purpose  : SPI master that emits OSD enable/disable/line-write frames.      |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module osd_spi_writer #(
   parameter int CLKDIV = 4,
   parameter int GAP    = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic [1:0]  req_op,
   input  logic [2:0]  req_line,
   output logic        busy,
   output logic        done,
   output logic        rd_en,
   output logic [10:0] rd_addr,
   input  logic [7:0]  rd_data,
   output logic        sck,
   output logic        ss,
   output logic        sdi
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_LO    = 3'd2,
      S_HI    = 3'd3,
      S_HOLD  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   localparam logic [7:0] c_div_last = 8'(CLKDIV - 1);
   localparam logic [7:0] c_gap_last = 8'(GAP - 1);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic [2:0] r_bit;
   logic [8:0] r_byte_idx;
   logic [7:0] r_shift;
   logic [7:0] r_pref;
   logic [1:0] r_op;
   logic [2:0] r_line;
   logic       r_cap;

   logic [7:0] w_cmd;
   logic       w_div_end;
   logic       w_last_byte;
   logic       w_fetch;

   always_comb begin
      w_cmd       = (req_op == 2'd2) ? {5'b00100, req_line} : {7'b0100000, req_op[0]};
      w_div_end   = (r_cnt == c_div_last);
      w_last_byte = (r_op != 2'd2) || (r_byte_idx == 9'd256);
      // frame byte b (b = 1..255) carries payload b-1 and prefetches payload b
      w_fetch     = (r_op == 2'd2) && (r_byte_idx != 9'd0) && !r_byte_idx[8];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= 8'd0;
         r_bit      <= 3'd0;
         r_byte_idx <= 9'd0;
         r_shift    <= 8'd0;
         r_pref     <= 8'd0;
         r_op       <= 2'd0;
         r_line     <= 3'd0;
         r_cap      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         rd_en      <= 1'b0;
         rd_addr    <= 11'd0;
         sck        <= 1'b0;
         ss         <= 1'b1;
         sdi        <= 1'b0;
      end else begin
         rd_en <= 1'b0;
         r_cap <= rd_en;
         if (r_cap) begin
            r_pref <= rd_data;
         end
         case (r_state)
            S_IDLE: begin
               if (req && req_op != 2'd3) begin
                  r_op       <= req_op;
                  r_line     <= req_line;
                  r_shift    <= w_cmd;
                  r_bit      <= 3'd7;
                  r_byte_idx <= 9'd0;
                  r_cnt      <= 8'd0;
                  sdi        <= w_cmd[7];
                  ss         <= 1'b0;
                  busy       <= 1'b1;
                  r_state    <= S_SETUP;
                  if (req_op == 2'd2) begin
                     rd_en   <= 1'b1;
                     rd_addr <= {req_line, 8'd0};
                  end
               end
            end
            S_SETUP: begin
               if (w_div_end) begin
                  r_cnt   <= 8'd0;
                  r_state <= S_LO;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_LO: begin
               if (r_cnt == 8'd0 && r_bit == 3'd7 && w_fetch) begin
                  rd_en   <= 1'b1;
                  rd_addr <= {r_line, r_byte_idx[7:0]};
               end
               if (w_div_end) begin
                  r_cnt   <= 8'd0;
                  sck     <= 1'b1;
                  r_state <= S_HI;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_HI: begin
               if (w_div_end) begin
                  r_cnt <= 8'd0;
                  sck   <= 1'b0;
                  if (r_bit != 3'd0) begin
                     r_bit   <= r_bit - 3'd1;
                     sdi     <= r_shift[r_bit - 3'd1];
                     r_state <= S_LO;
                  end else if (w_last_byte) begin
                     r_state <= S_HOLD;
                  end else begin
                     r_shift    <= r_pref;
                     sdi        <= r_pref[7];
                     r_bit      <= 3'd7;
                     r_byte_idx <= r_byte_idx + 9'd1;
                     r_state    <= S_LO;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_HOLD: begin
               if (w_div_end) begin
                  r_cnt   <= 8'd0;
                  ss      <= 1'b1;
                  sdi     <= 1'b0;
                  done    <= (c_gap_last == 8'd0);
                  r_state <= S_GAP;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_GAP: begin
               if (r_cnt == c_gap_last) begin
                  r_cnt   <= 8'd0;
                  busy    <= 1'b0;
                  done    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
                  done  <= ((r_cnt + 8'd1) == c_gap_last);
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_osd_spi_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_osd_spi_writer                                                |
// | Purpose  : Bench for osd_spi_writer with an SPI-slave decoder and RAM model.|
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_osd_spi_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_n;

   logic        req_a, busy_a, done_a, rd_en_a, sck_a, ss_a, sdi_a;
   logic [1:0]  req_op_a;
   logic [2:0]  req_line_a;
   logic [10:0] rd_addr_a;
   logic [7:0]  rd_data_a;
   logic        req_b, busy_b, done_b, rd_en_b, sck_b, ss_b, sdi_b;
   logic [1:0]  req_op_b;
   logic [2:0]  req_line_b;
   logic [10:0] rd_addr_b;
   logic [7:0]  rd_data_b;

   osd_spi_writer #(.CLKDIV(4), .GAP(4)) dut (
      .clk(clk), .reset_n(reset_n), .req(req_a), .req_op(req_op_a), .req_line(req_line_a),
      .busy(busy_a), .done(done_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
      .sck(sck_a), .ss(ss_a), .sdi(sdi_a));

   osd_spi_writer #(.CLKDIV(1), .GAP(1)) dut_fast (
      .clk(clk), .reset_n(reset_n), .req(req_b), .req_op(req_op_b), .req_line(req_line_b),
      .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
      .sck(sck_b), .ss(ss_b), .sdi(sdi_b));

   logic [7:0]  mem [0:2047];
   logic [7:0]  exp_q [$];
   logic [7:0]  bytes_a [$], bytes_b [$];
   logic [10:0] addr_a [$], addr_b [$];
   logic [7:0]  sh_a = 8'd0, sh_b = 8'd0;
   int nbit_a = 0, nbit_b = 0, rises_a = 0, rises_b = 0, ends_a = 0, ends_b = 0;
   int bad_a = 0, bad_b = 0;
   int checks = 0, errors = 0;

   // staging RAM: synchronous read, data valid the cycle after rd_en
   always @(posedge clk) if (rd_en_a === 1'b1) rd_data_a <= mem[rd_addr_a];
   always @(posedge clk) if (rd_en_b === 1'b1) rd_data_b <= mem[rd_addr_b];
   always @(posedge clk) if (rd_en_a === 1'b1) addr_a.push_back(rd_addr_a);
   always @(posedge clk) if (rd_en_b === 1'b1) addr_b.push_back(rd_addr_b);

   // SPI slave: sample sdi on sck rise while selected; ss rising ends the frame
   always @(posedge sck_a or posedge ss_a) begin
      if (ss_a === 1'b1) begin
         nbit_a = 0; ends_a++;
      end else begin
         sh_a = {sh_a[6:0], sdi_a}; rises_a++; nbit_a++;
         if (nbit_a == 8) begin bytes_a.push_back(sh_a); nbit_a = 0; end
      end
   end
   always @(posedge sck_b or posedge ss_b) begin
      if (ss_b === 1'b1) begin
         nbit_b = 0; ends_b++;
      end else begin
         sh_b = {sh_b[6:0], sdi_b}; rises_b++; nbit_b++;
         if (nbit_b == 8) begin bytes_b.push_back(sh_b); nbit_b = 0; end
      end
   end
   always @(posedge sck_a) if (ss_a !== 1'b0) bad_a++;
   always @(posedge sck_b) if (ss_b !== 1'b0) bad_b++;

   task automatic build_exp(input logic [1:0] op, input logic [2:0] line);
      case (op)
         2'd0: exp_q.push_back(8'h40);
         2'd1: exp_q.push_back(8'h41);
         2'd2: begin
            exp_q.push_back(8'h20 | {5'd0, line});
            for (int k = 0; k < 256; k++) exp_q.push_back(mem[int'(line) * 256 + k]);
         end
         default: ;
      endcase
   endtask

   function automatic int diff_bytes(input int sel, input int start);
      int d, n;
      logic [7:0] v;
      d = 0;
      n = (sel != 0) ? bytes_b.size() : bytes_a.size();
      if (n - start != exp_q.size()) d++;
      for (int i = 0; i < exp_q.size() && start + i < n; i++) begin
         v = (sel != 0) ? bytes_b[start + i] : bytes_a[start + i];
         if (v !== exp_q[i]) d++;
      end
      return d;
   endfunction

   function automatic int diff_addr(input int sel, input int start, input logic [2:0] line);
      int d, n;
      logic [10:0] v;
      d = 0;
      n = (sel != 0) ? addr_b.size() : addr_a.size();
      if (n - start != 256) d++;
      for (int k = 0; k < 256 && start + k < n; k++) begin
         v = (sel != 0) ? addr_b[start + k] : addr_a[start + k];
         if (v !== {line, k[7:0]}) d++;
      end
      return d;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
   endtask

   // issues one request and follows it until busy drops
   task automatic send(input int sel, input logic [1:0] op, input logic [2:0] line,
                       output int ss_low, output int ndone, output bit acc,
                       output bit order_ok, output bit tmo);
      int n, done_at;
      ss_low = 0; ndone = 0; done_at = -1;
      @(negedge clk);
      if (sel == 0) begin req_a = 1'b1; req_op_a = op; req_line_a = line; end
      else begin req_b = 1'b1; req_op_b = op; req_line_b = line; end
      @(negedge clk);
      req_a = 1'b0; req_b = 1'b0;
      acc = (sel != 0) ? busy_b : busy_a;
      n = 0;
      while (((sel != 0) ? busy_b : busy_a) === 1'b1 && n < 20000) begin
         if (((sel != 0) ? ss_b : ss_a) === 1'b0) ss_low++;
         if (((sel != 0) ? done_b : done_a) === 1'b1) begin ndone++; done_at = n; end
         @(negedge clk);
         n++;
      end
      tmo = (n >= 20000);
      order_ok = !tmo && (done_at == n - 1);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({ss_a, sck_a, sdi_a, busy_a, done_a, rd_en_a} !== 6'b100000) begin errors++; $display("FAIL reset_ctrl_in_reset: got %b expected 100000", {ss_a, sck_a, sdi_a, busy_a, done_a, rd_en_a}); end
      reset_n = 1'b1;
      @(negedge clk);
      checks++; if ({ss_a, sck_a, sdi_a, busy_a, done_a, rd_en_a} !== 6'b100000) begin errors++; $display("FAIL reset_ctrl_after: got %b expected 100000", {ss_a, sck_a, sdi_a, busy_a, done_a, rd_en_a}); end
      checks++; if (rd_addr_a !== 11'd0) begin errors++; $display("FAIL reset_rd_addr: got %h expected 000", rd_addr_a); end
      checks++; if ({ss_b, sck_b, busy_b, rd_en_b} !== 4'b1000) begin errors++; $display("FAIL reset_fast: got %b expected 1000", {ss_b, sck_b, busy_b, rd_en_b}); end
   endtask

   task automatic test_op1();
      int ss_low, ndone, b0, r0; bit acc, ok, tmo;
      exp_q.delete(); build_exp(2'd1, 3'd0);
      b0 = bytes_a.size(); r0 = rises_a;
      send(0, 2'd1, 3'd0, ss_low, ndone, acc, ok, tmo);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL op1_accept: busy=%b expected 1", acc); end
      checks++; if (tmo) begin errors++; $display("FAIL op1_timeout: busy stuck high, expected release"); end
      checks++; if (ss_low != 72) begin errors++; $display("FAIL op1_ss_low: got %0d expected 72", ss_low); end
      checks++; if (rises_a - r0 != 8) begin errors++; $display("FAIL op1_rises: got %0d expected 8", rises_a - r0); end
      checks++; if (diff_bytes(0, b0) != 0) begin errors++; $display("FAIL op1_bytes: %0d byte errors, expected 0", diff_bytes(0, b0)); end
      checks++; if (ndone != 1 || !ok) begin errors++; $display("FAIL op1_done: pulses=%0d order=%0d expected 1/1", ndone, ok); end
   endtask

   task automatic test_back_to_back();
      int b0, e0, n, hi; bit acc1, acc2, ss_second;
      exp_q.delete(); build_exp(2'd0, 3'd0); build_exp(2'd1, 3'd0);
      b0 = bytes_a.size(); e0 = ends_a;
      @(negedge clk); req_a = 1'b1; req_op_a = 2'd0; req_line_a = 3'd0;
      @(negedge clk); acc1 = busy_a; req_op_a = 2'd1;
      n = 0; hi = 0;
      while (busy_a === 1'b1 && n < 20000) begin
         if (ss_a === 1'b1) hi++;
         @(negedge clk); n++;
      end
      if (ss_a === 1'b1) hi++;
      @(negedge clk); req_a = 1'b0;
      acc2 = busy_a; ss_second = ~ss_a;
      n = 0;
      while (busy_a === 1'b1 && n < 20000) begin @(negedge clk); n++; end
      checks++; if (!acc1 || !acc2) begin errors++; $display("FAIL b2b_accept: got %b%b expected 11", acc1, acc2); end
      checks++; if (hi != 5 || !ss_second) begin errors++; $display("FAIL b2b_ss_high: got %0d cycles (second low=%0d) expected 5 (1)", hi, ss_second); end
      checks++; if (diff_bytes(0, b0) != 0) begin errors++; $display("FAIL b2b_bytes: %0d byte errors, expected 0", diff_bytes(0, b0)); end
      checks++; if (ends_a - e0 != 2) begin errors++; $display("FAIL b2b_frames: got %0d expected 2", ends_a - e0); end
   endtask

   task automatic test_ignored();
      int e0, b0, n; bit saw_busy, saw_low;
      e0 = ends_a; saw_busy = 0; saw_low = 0;
      @(negedge clk); req_a = 1'b1; req_op_a = 2'd3; req_line_a = 3'd2;
      @(negedge clk); req_a = 1'b0;
      repeat (20) begin
         if (busy_a !== 1'b0) saw_busy = 1;
         if (ss_a !== 1'b1) saw_low = 1;
         @(negedge clk);
      end
      checks++; if (saw_busy || saw_low) begin errors++; $display("FAIL op3_ignored: busy_seen=%0d ss_low_seen=%0d expected 0/0", saw_busy, saw_low); end
      checks++; if (ends_a != e0) begin errors++; $display("FAIL op3_frames: got %0d expected 0", ends_a - e0); end
      // requests raised mid-frame must be dropped, not queued
      exp_q.delete(); build_exp(2'd1, 3'd0);
      b0 = bytes_a.size(); e0 = ends_a;
      @(negedge clk); req_a = 1'b1; req_op_a = 2'd1;
      @(negedge clk);
      n = 0;
      while (busy_a === 1'b1 && n < 20000) begin
         req_a = (n % 7 == 3); req_op_a = 2'd0;
         @(negedge clk); n++;
      end
      req_a = 1'b0;
      repeat (30) @(negedge clk);
      checks++; if (ends_a - e0 != 1 || busy_a !== 1'b0) begin errors++; $display("FAIL busy_req_frames: got %0d busy=%b expected 1 busy=0", ends_a - e0, busy_a); end
      checks++; if (diff_bytes(0, b0) != 0) begin errors++; $display("FAIL busy_req_bytes: %0d byte errors, expected 0", diff_bytes(0, b0)); end
   endtask

   task automatic test_random_seq();
      int ss_low, ndone, b0, e0, pick; bit acc, ok, tmo;
      logic [1:0] op;
      for (int i = 0; i < 6; i++) begin
         pick = $urandom_range(0, 2);
         op = (pick == 2) ? 2'd3 : 2'(pick);
         exp_q.delete(); build_exp(op, 3'(i));
         b0 = bytes_a.size(); e0 = ends_a;
         send(0, op, 3'(i), ss_low, ndone, acc, ok, tmo);
         repeat (3) @(negedge clk);
         checks++; if (acc !== (op != 2'd3) || diff_bytes(0, b0) != 0 || ends_a - e0 != exp_q.size()) begin
            errors++; $display("FAIL rand_op%0d_%0d: acc=%b frames=%0d byte_err=%0d expected acc=%b frames=%0d", op, i, acc, ends_a - e0, diff_bytes(0, b0), op != 2'd3, exp_q.size());
         end
      end
   endtask

   task automatic test_line_write();
      int ss_low, ndone, b0, r0, a0; bit acc, ok, tmo;
      logic [2:0] line;
      for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'hA5;
      exp_q.delete(); build_exp(2'd2, 3'd5);
      b0 = bytes_a.size(); r0 = rises_a; a0 = addr_a.size();
      send(0, 2'd2, 3'd5, ss_low, ndone, acc, ok, tmo);
      checks++; if (!acc || tmo) begin errors++; $display("FAIL line5_accept: acc=%b timeout=%0d expected 1/0", acc, tmo); end
      checks++; if (ss_low != 16456) begin errors++; $display("FAIL line5_ss_low: got %0d expected 16456", ss_low); end
      checks++; if (rises_a - r0 != 2056) begin errors++; $display("FAIL line5_rises: got %0d expected 2056", rises_a - r0); end
      checks++; if (diff_bytes(0, b0) != 0) begin errors++; $display("FAIL line5_bytes: %0d byte errors, expected 0", diff_bytes(0, b0)); end
      checks++; if (diff_addr(0, a0, 3'd5) != 0) begin errors++; $display("FAIL line5_rd: %0d addr errors (count %0d) expected 0 (256)", diff_addr(0, a0, 3'd5), addr_a.size() - a0); end
      checks++; if (ndone != 1 || !ok) begin errors++; $display("FAIL line5_done: pulses=%0d order=%0d expected 1/1", ndone, ok); end
      fill_random();
      line = 3'($urandom_range(0, 7));
      exp_q.delete(); build_exp(2'd2, line);
      b0 = bytes_a.size(); a0 = addr_a.size();
      send(0, 2'd2, line, ss_low, ndone, acc, ok, tmo);
      checks++; if (diff_bytes(0, b0) != 0) begin errors++; $display("FAIL rand_line%0d_bytes: %0d byte errors, expected 0", line, diff_bytes(0, b0)); end
      checks++; if (diff_addr(0, a0, line) != 0) begin errors++; $display("FAIL rand_line%0d_rd: %0d addr errors, expected 0", line, diff_addr(0, a0, line)); end
   endtask

   task automatic test_clkdiv1();
      int ss_low, ndone, b0, r0, a0; bit acc, ok, tmo;
      logic [2:0] line;
      fill_random();
      line = 3'($urandom_range(0, 7));
      exp_q.delete(); build_exp(2'd2, line);
      b0 = bytes_b.size(); r0 = rises_b; a0 = addr_b.size();
      send(1, 2'd2, line, ss_low, ndone, acc, ok, tmo);
      checks++; if (!acc || tmo) begin errors++; $display("FAIL div1_accept: acc=%b timeout=%0d expected 1/0", acc, tmo); end
      checks++; if (ss_low != 4114) begin errors++; $display("FAIL div1_ss_low: got %0d expected 4114", ss_low); end
      checks++; if (rises_b - r0 != 2056) begin errors++; $display("FAIL div1_rises: got %0d expected 2056", rises_b - r0); end
      checks++; if (diff_bytes(1, b0) != 0) begin errors++; $display("FAIL div1_bytes: %0d byte errors, expected 0", diff_bytes(1, b0)); end
      checks++; if (diff_addr(1, a0, line) != 0) begin errors++; $display("FAIL div1_rd: %0d addr errors, expected 0", diff_addr(1, a0, line)); end
      checks++; if (ndone != 1 || !ok) begin errors++; $display("FAIL div1_done: pulses=%0d order=%0d expected 1/1", ndone, ok); end
   endtask

   task automatic test_reset_mid();
      int ss_low, ndone, b0, n, d; bit acc, ok, tmo;
      logic [2:0] line;
      fill_random();
      line = 3'($urandom_range(0, 7));
      exp_q.delete(); build_exp(2'd2, line);
      b0 = bytes_a.size();
      @(negedge clk); req_a = 1'b1; req_op_a = 2'd2; req_line_a = line;
      @(negedge clk); req_a = 1'b0;
      n = 0;
      while (bytes_a.size() < b0 + 101 && n < 20000) begin @(negedge clk); n++; end
      checks++; if (n >= 20000) begin errors++; $display("FAIL rstmid_reach: got %0d bytes expected 101", bytes_a.size() - b0); end
      d = 0;
      for (int i = 0; i < 101 && b0 + i < bytes_a.size(); i++) if (bytes_a[b0 + i] !== exp_q[i]) d++;
      checks++; if (d != 0) begin errors++; $display("FAIL rstmid_prefix: %0d byte errors, expected 0", d); end
      repeat ($urandom_range(0, 20)) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++; if ({ss_a, sck_a, busy_a, rd_en_a} !== 4'b1000) begin errors++; $display("FAIL rstmid_async: got %b expected 1000", {ss_a, sck_a, busy_a, rd_en_a}); end
      @(negedge clk); @(negedge clk); reset_n = 1'b1;
      @(negedge clk);
      exp_q.delete(); build_exp(2'd1, 3'd0);
      b0 = bytes_a.size();
      send(0, 2'd1, 3'd0, ss_low, ndone, acc, ok, tmo);
      checks++; if (diff_bytes(0, b0) != 0 || ss_low != 72 || !ok) begin errors++; $display("FAIL rstmid_next: byte_err=%0d ss_low=%0d done_ok=%0d expected 0/72/1", diff_bytes(0, b0), ss_low, ok); end
      checks++; if (bad_a != 0 || bad_b != 0) begin errors++; $display("FAIL sck_while_deselected: got %0d/%0d expected 0/0", bad_a, bad_b); end
   endtask

   initial begin
      reset_n = 1'b0;
      req_a = 1'b0; req_op_a = 2'd0; req_line_a = 3'd0;
      req_b = 1'b0; req_op_b = 2'd0; req_line_b = 3'd0;
      for (int i = 0; i < 2048; i++) mem[i] = 8'd0;
      test_reset();
      test_op1();
      test_back_to_back();
      test_ignored();
      test_random_seq();
      test_line_write();
      test_clkdiv1();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/osd_spi_writer.md
Name: osd_spi_writer

Overview:
- Host-side SPI master that drives the OSD's sck/ss/sdi link, producing the command stream the display-side OSD receiver decodes.
- Accepts high-level requests from the IO-controller logic: OSD enable, OSD disable, and write one 256-byte OSD line.
- For line writes, it fetches payload bytes from a local 2048-byte staging RAM through a synchronous read port.
- Sits between the host control logic and the OSD link pins.

Parameters:
- CLKDIV, 4: sck half-period in clk cycles; legal range 1-255.
- GAP, 4: minimum ss-high time between frames, in clk cycles; legal range 1-255.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only while busy=0.
- req_op  in  2  request opcode: 0 = disable, 1 = enable, 2 = write line, 3 = reserved (ignored, no frame).
- req_line  in  3  OSD line 0-7; used only for op 2.
- busy  out  1  high from the cycle after an accepted req until the GAP phase completes.
- done  out  1  one-cycle pulse in the last GAP cycle.
- rd_en  out  1  staging RAM read strobe.
- rd_addr  out  11  staging RAM address = {line, byte_idx[7:0]}.
- rd_data  in  8  RAM data, valid the cycle after rd_en.
- sck  out  1  SPI clock; idle low.
- ss  out  1  slave select; active low, idle high.
- sdi  out  1  serial data to the OSD, MSB first.

Behaviour:
- Reset (asynchronous, immediate): ss=1, sck=0, sdi=0, busy=0, done=0, rd_en=0, rd_addr=0, FSM=IDLE, counters=0.
- Reset mid-frame: ss rises immediately and the frame is abandoned.
- Accept: req=1 and busy=0 and req_op!=3 → latch op/line; busy=1 next cycle.
- Accept with req_op=3: ignored; busy stays 0.
- req while busy=1: ignored; no queueing.
- Command byte: op0 = 0x40, op1 = 0x41, op2 = 0x20 | line.
- Frame length: 1 byte for op0/op1; 257 bytes (command plus payload 0..255) for op2.
- FSM states: IDLE → SETUP → (LO ↔ HI per bit) → HOLD → GAP → IDLE.
- SETUP: ss=0 and sdi = command MSB; lasts CLKDIV cycles.
- LO: sck=0 with sdi stable; lasts CLKDIV cycles, then goes to HI.
- HI: sck=1; the slave samples on this rising edge; lasts CLKDIV cycles.
- End of HI: sck falls; sdi advances to the next bit in the same cycle.
- Bit order: each byte is 8 bits, MSB first; consecutive bytes have no idle gap between them.
- Rising-edge count: frame has exactly 8×N rising sck edges, where N = number of bytes.
- Payload fetch: for op2, rd_en pulses for one cycle with rd_addr={line,k}.
  - k=0 is fetched in the SETUP cycle.
  - Byte k+1 is fetched in the first LO cycle of byte k's bit 7.
  - rd_data is captured into a prefetch register the following cycle, which is required to be before the byte boundary (holds for CLKDIV≥1).
- rd_en count: exactly 256 pulses per line write; addresses increment 0→255 with no wrap into the next line.
- HOLD: after the final HI phase, sck=0 and ss=0 for CLKDIV cycles; then ss=1.
- GAP: ss=1 for GAP cycles; done pulses in the last GAP cycle; busy=0 the cycle after.
- Back-to-back requests: req asserted in the cycle busy falls is accepted, which gives a minimum ss-high time of GAP+1 cycles.
- Output timing: sck/ss/sdi are registered (glitch-free); sck never toggles while ss=1.

Test Plan:
- Reset release, then req op1 with CLKDIV=4 → ss low for 4+64+4 cycles; 8 sck rises; sdi bits 0,1,0,0,0,0,0,1; done pulse; busy low after GAP.
- op0 then op1 back-to-back with req held high → two frames, 0x40 then 0x41, separated by ss high for ≥5 cycles.
- op2 line=5, RAM preloaded with byte = addr[7:0]^0xA5 → frame of 0x25 followed by 256 bytes matching RAM 0x500-0x5FF; 2056 sck rises; 256 rd_en pulses.
- op2 with CLKDIV=1 → continuous payload with no stretched bit; bench SPI-slave model decodes every byte correctly.
- req asserted during busy, and req_op=3 in IDLE → no additional frame; ss stays high for the op3 case.
- reset_n pulled low at payload byte 100 → ss=1 and sck=0 the same cycle; a subsequent op1 frame is well-formed.
